ram_port_arbiter: RTL and testbench

// Shares the single 96x256 coefficient RAM among its five masters: coder, ntt, addsub, A_gen and CBD.

---
 rtl/ram_port_arbiter_pkg.sv | 27 ++
 rtl/ram_port_arbiter_rr_pick.sv | 48 ++++
 rtl/ram_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_ram_port_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// ram_port_arbiter_pkg
//   Shared definitions for the coefficient-RAM port arbiter: default
//   geometry of the 96x256 RAM, master index assignment and the arbiter
//   state type.
package ram_port_arbiter_pkg;

    localparam int N_REQ_DEF     = 5;
    localparam int AW_DEF        = 8;
    localparam int DW_DEF        = 96;
    localparam int READ_LAT_DEF  = 1;
    localparam int MAX_BURST_DEF = 256;

    // Width of the owner index and round-robin pointer.
    localparam int OW = 3;

    localparam logic [OW-1:0] MST_CODER  = 3'd0;
    localparam logic [OW-1:0] MST_NTT    = 3'd1;
    localparam logic [OW-1:0] MST_ADDSUB = 3'd2;
    localparam logic [OW-1:0] MST_A_GEN  = 3'd3;
    localparam logic [OW-1:0] MST_CBD    = 3'd4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/ram_port_arbiter_rr_pick.sv
// ram_port_arbiter_rr_pick
//   Combinational round-robin picker. Scans rr_ptr+1, rr_ptr+2, ... (mod
//   N_REQ) and returns the first requester found. The master at rr_ptr
//   itself is considered last, which is what lets a burst-limited owner
//   yield to any waiting master.
// Ports
//   req      in   N_REQ  request vector
//   rr_ptr   in   OW     index of the most recent winner
//   win      out  N_REQ  one-hot winner (zero when no request)
//   win_idx  out  OW     index of the winner
//   any      out  1      at least one request present
module ram_port_arbiter_rr_pick
    import ram_port_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
) (
    input  logic [N_REQ-1:0] req,
    input  logic [OW-1:0]    rr_ptr,
    output logic [N_REQ-1:0] win,
    output logic [OW-1:0]    win_idx,
    output logic             any
);

    always_comb begin
        win     = '0;
        win_idx = '0;
        any     = 1'b0;
        // First pass: indices above the pointer, lowest first.
        for (int i = 0; i < N_REQ; i++) begin
            if (!any && req[i] && (i > int'(rr_ptr))) begin
                any     = 1'b1;
                win     = '0;
                win[i]  = 1'b1;
                win_idx = OW'(i);
            end
        end
        // Wrap-around pass: indices up to and including the pointer.
        for (int i = 0; i < N_REQ; i++) begin
            if (!any && req[i]) begin
                any     = 1'b1;
                win     = '0;
                win[i]  = 1'b1;
                win_idx = OW'(i);
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares the single coefficient RAM among coder, ntt, addsub, A_gen and
//   CBD with a req/gnt handshake. Round-robin grant, burst ownership with an
//   optional burst limit, and per-master read-valid routing.
// Ports
//   clk        in   1         system clock
//   rst        in   1         asynchronous reset, active-low
//   req        in   N_REQ     per-master ownership request
//   ren/wen    in   N_REQ     per-master read / write strobes
//   raddr      in   N_REQ*AW  per-master read address
//   waddr      in   N_REQ*AW  per-master write address
//   wdata      in   N_REQ*DW  per-master write data
//   gnt        out  N_REQ     registered one-hot grant
//   rvalid     out  N_REQ     read data valid, routed to issuing master
//   rdata      out  DW        RAM dout broadcast
//   ram_*      out            RAM write enable, addresses and write data
//   ram_din    in   DW        RAM dout
//   busy       out  1         any grant active
//   owner      out  OW        granted master index, valid while busy
//
// state    | meaning
// ST_IDLE  | no master owns the RAM, RAM strobes forced off
// ST_BUSY  | one master owns the RAM; burst_cnt counts its owned cycles
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int AW        = AW_DEF,
    parameter int DW        = DW_DEF,
    parameter int READ_LAT  = READ_LAT_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    ren,
    input  logic [N_REQ*AW-1:0] raddr,
    input  logic [N_REQ-1:0]    wen,
    input  logic [N_REQ*AW-1:0] waddr,
    input  logic [N_REQ*DW-1:0] wdata,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    rvalid,
    output logic [DW-1:0]       rdata,
    output logic                ram_wen,
    output logic [AW-1:0]       ram_raddr,
    output logic [AW-1:0]       ram_waddr,
    output logic [DW-1:0]       ram_wdata,
    input  logic [DW-1:0]       ram_din,
    output logic                busy,
    output logic [OW-1:0]       owner
);

    localparam int CNT_W = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;
    // With no limit the counter simply saturates at all-ones.
    localparam logic [CNT_W-1:0] CNT_LAST =
        (MAX_BURST == 0) ? {CNT_W{1'b1}} : CNT_W'(MAX_BURST - 1);

    arb_state_t         state;
    logic [OW-1:0]      rr_ptr;
    logic [CNT_W-1:0]   burst_cnt;
    logic [N_REQ-1:0]   pick_win;
    logic [OW-1:0]      pick_idx;
    logic               pick_any;
    logic               owner_req;
    logic               others_wait;
    logic               limit_hit;
    logic [N_REQ-1:0]   rd_pipe [READ_LAT];

    ram_port_arbiter_rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .win     (pick_win),
        .win_idx (pick_idx),
        .any     (pick_any)
    );

    assign owner_req   = |(req & gnt);
    assign others_wait = |(req & ~gnt);
    assign limit_hit   = (MAX_BURST != 0) && (burst_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            gnt       <= '0;
            busy      <= 1'b0;
            owner     <= '0;
            rr_ptr    <= OW'(N_REQ - 1);
            burst_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        state     <= ST_BUSY;
                        gnt       <= pick_win;
                        busy      <= 1'b1;
                        owner     <= pick_idx;
                        rr_ptr    <= pick_idx;
                        burst_cnt <= '0;
                    end
                end
                ST_BUSY: begin
                    // The owner sits at rr_ptr, so it is scanned last; when it
                    // has dropped req it is not a candidate at all.
                    if (!owner_req || (limit_hit && others_wait)) begin
                        if (pick_any) begin
                            gnt       <= pick_win;
                            owner     <= pick_idx;
                            rr_ptr    <= pick_idx;
                            burst_cnt <= '0;
                        end else begin
                            state <= ST_IDLE;
                            gnt   <= '0;
                            busy  <= 1'b0;
                            owner <= '0;
                        end
                    end else if (burst_cnt != CNT_LAST) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Read-return pipe tagged with the issuing master, so data issued just
    // before a handover still lands at the right master.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < READ_LAT; i++) rd_pipe[i] <= '0;
        end else begin
            rd_pipe[0] <= ren & gnt;
            for (int i = 1; i < READ_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
    end

    assign rvalid = rd_pipe[READ_LAT-1];
    assign rdata  = ram_din;

    // AND-OR mux keyed on the one-hot grant: everything is zero when idle.
    always_comb begin
        ram_raddr = '0;
        ram_waddr = '0;
        ram_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                ram_raddr = ram_raddr | raddr[i*AW +: AW];
                ram_waddr = ram_waddr | waddr[i*AW +: AW];
                ram_wdata = ram_wdata | wdata[i*DW +: DW];
            end
        end
    end

    assign ram_wen = |(wen & gnt);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
//   Self-checking bench for ram_port_arbiter with a behavioural 96x256 RAM
//   (one-cycle read latency) and a read-return scoreboard.
module tb_ram_port_arbiter;
    import ram_port_arbiter_pkg::*;

    localparam int N  = 5;
    localparam int AW = 8;
    localparam int DW = 96;
    localparam int MB = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req, ren, wen;
    logic [N*AW-1:0]   raddr, waddr;
    logic [N*DW-1:0]   wdata;
    logic [N-1:0]      gnt, rvalid;
    logic [DW-1:0]     rdata, ram_wdata, ram_din;
    logic              ram_wen, busy;
    logic [AW-1:0]     ram_raddr, ram_waddr;
    logic [2:0]        owner;

    logic [DW-1:0]     mem [256];

    typedef struct {
        int            mst;
        logic [DW-1:0] data;
    } rd_exp_t;

    rd_exp_t sb[$];
    rd_exp_t mon_e;
    logic [N-1:0] mon_ev;

    int n_vec = 0;
    int n_err = 0;

    ram_port_arbiter #(
        .N_REQ(N), .AW(AW), .DW(DW), .READ_LAT(1), .MAX_BURST(MB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .ren       (ren),
        .raddr     (raddr),
        .wen       (wen),
        .waddr     (waddr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .ram_wen   (ram_wen),
        .ram_raddr (ram_raddr),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .ram_din   (ram_din),
        .busy      (busy),
        .owner     (owner)
    );

    always #5 clk = ~clk;

    // Behavioural RAM
    always @(posedge clk) begin
        if (ram_wen) mem[ram_waddr] <= ram_wdata;
        ram_din <= mem[ram_raddr];
    end

    // Read-return scoreboard
    always @(negedge clk) begin
        if (|rvalid) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL rd_unexpected rvalid=%b rdata=%h, none expected", rvalid, rdata);
            end else begin
                mon_e  = sb.pop_front();
                mon_ev = N'(1) << mon_e.mst;
                if (rvalid !== mon_ev || rdata !== mon_e.data) begin
                    n_err++;
                    $display("FAIL rd_return rvalid=%b rdata=%h want rvalid=%b rdata=%h",
                             rvalid, rdata, mon_ev, mon_e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic set_rd(input int m, input logic [AW-1:0] a);
        raddr[m*AW +: AW] = a;
    endtask

    task automatic set_wr(input int m, input logic [AW-1:0] a, input logic [DW-1:0] d);
        waddr[m*AW +: AW] = a;
        wdata[m*DW +: DW] = d;
    endtask

    task automatic idle_all();
        req = '0;
        ren = '0;
        wen = '0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        req = 5'b11111;
        ren = 5'b11111;
        wen = 5'b11111;
        set_wr(MST_CODER, 8'h40, 96'h1234);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++; if (gnt !== 5'b0)    begin n_err++; $display("FAIL reset_gnt got=%b want=%b", gnt, 5'b0); end
        n_vec++; if (rvalid !== 5'b0) begin n_err++; $display("FAIL reset_rvalid got=%b want=%b", rvalid, 5'b0); end
        n_vec++; if (ram_wen !== 1'b0) begin n_err++; $display("FAIL reset_ram_wen got=%b want=0", ram_wen); end
        n_vec++; if (busy !== 1'b0)   begin n_err++; $display("FAIL reset_busy got=%b want=0", busy); end
        @(posedge clk); #1;
        rst = 1'b1;
        ren = '0;
        wen = '0;
        #1;
        n_vec++; if (gnt !== 5'b0) begin n_err++; $display("FAIL release_gnt_early got=%b want=%b", gnt, 5'b0); end
        @(posedge clk);
        @(negedge clk);
        n_vec++; if (gnt !== 5'b00001) begin n_err++; $display("FAIL release_gnt got=%b want=%b", gnt, 5'b00001); end
        n_vec++; if (owner !== 3'd0 || busy !== 1'b1) begin n_err++; $display("FAIL release_owner got=%0d/%b want=0/1", owner, busy); end
        @(posedge clk); #1;
        idle_all();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_g;
        req = 5'b10110;
        @(posedge clk);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            exp_g = (i < 4) ? 5'b00010 : (i < 8) ? 5'b00100 : (i < 12) ? 5'b10000 : 5'b00010;
            n_vec++;
            if (gnt !== exp_g) begin
                n_err++;
                $display("FAIL rr_order cycle=%0d got=%b want=%b", i, gnt, exp_g);
            end
            if (i < 15) @(posedge clk);
        end
        @(posedge clk); #1;
        idle_all();
    endtask

    task automatic test_release_handover();
        req = 5'b00010;
        @(posedge clk);
        @(negedge clk);
        n_vec++; if (gnt !== 5'b00010) begin n_err++; $display("FAIL ho_first got=%b want=%b", gnt, 5'b00010); end
        @(posedge clk); #1;
        req = 5'b00100;
        @(negedge clk);
        n_vec++; if (gnt !== 5'b00010) begin n_err++; $display("FAIL ho_before got=%b want=%b", gnt, 5'b00010); end
        @(posedge clk);
        @(negedge clk);
        n_vec++; if (gnt !== 5'b00100 || busy !== 1'b1) begin n_err++; $display("FAIL ho_move got=%b/%b want=%b/1", gnt, busy, 5'b00100); end
        @(posedge clk); #1;
        req = '0;
        @(posedge clk);
        @(negedge clk);
        n_vec++; if (busy !== 1'b0 || gnt !== 5'b0) begin n_err++; $display("FAIL ho_idle got=%b/%b want=%b/0", gnt, busy, 5'b0); end
        @(posedge clk); #1;
    endtask

    task automatic test_read_routing();
        set_rd(MST_NTT, 8'h10);
        set_rd(MST_ADDSUB, 8'h11);
        req = 5'b00110;
        repeat (3) @(posedge clk);
        @(posedge clk); #1;
        ren = 5'b00010;
        sb.push_back('{mst: 1, data: 96'hA5});
        @(negedge clk);
        n_vec++; if (gnt !== 5'b00010) begin n_err++; $display("FAIL rd_last_owned got=%b want=%b", gnt, 5'b00010); end
        @(posedge clk); #1;
        ren = 5'b00100;
        sb.push_back('{mst: 2, data: 96'h5A5A_0011});
        @(negedge clk);
        n_vec++; if (gnt !== 5'b00100) begin n_err++; $display("FAIL rd_gnt_moved got=%b want=%b", gnt, 5'b00100); end
        n_vec++; if (rvalid !== 5'b00010 || rdata !== 96'hA5) begin n_err++; $display("FAIL rd_ntt got=%b/%h want=%b/%h", rvalid, rdata, 5'b00010, 96'hA5); end
        @(posedge clk); #1;
        ren = '0;
        @(negedge clk);
        n_vec++; if (rvalid !== 5'b00100 || rdata !== 96'h5A5A_0011) begin n_err++; $display("FAIL rd_addsub got=%b/%h want=%b/%h", rvalid, rdata, 5'b00100, 96'h5A5A_0011); end
        @(posedge clk); #1;
        idle_all();
    endtask

    task automatic test_write_gating();
        logic [DW-1:0] w;
        logic [DW-1:0] orig;
        w    = 96'hFEED_0000_1111_2222_C8D0;
        orig = {64'h0, 24'hC0DE00, 8'h20};
        set_wr(MST_CBD, 8'h20, w);
        wen = 5'b10000;
        @(posedge clk);
        @(negedge clk);
        n_vec++; if (ram_wen !== 1'b0) begin n_err++; $display("FAIL wg_idle_wen got=%b want=0", ram_wen); end
        @(posedge clk); #1;
        req = 5'b00001;
        @(posedge clk);
        @(negedge clk);
        n_vec++; if (gnt !== 5'b00001 || ram_wen !== 1'b0) begin n_err++; $display("FAIL wg_other_owner got=%b/%b want=%b/0", gnt, ram_wen, 5'b00001); end
        n_vec++; if (mem[8'h20] !== orig) begin n_err++; $display("FAIL wg_unchanged got=%h want=%h", mem[8'h20], orig); end
        @(posedge clk); #1;
        req = 5'b10000;
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (gnt !== 5'b10000 || ram_wen !== 1'b1 || ram_waddr !== 8'h20 || ram_wdata !== w) begin
            n_err++;
            $display("FAIL wg_granted got=%b/%b/%h/%h want=%b/1/20/%h", gnt, ram_wen, ram_waddr, ram_wdata, 5'b10000, w);
        end
        @(posedge clk); #1;
        wen = '0;
        n_vec++; if (mem[8'h20] !== w) begin n_err++; $display("FAIL wg_written got=%h want=%h", mem[8'h20], w); end
        idle_all();
    endtask

    task automatic test_async_reset();
        logic [DW-1:0] w1;
        logic [DW-1:0] w2;
        logic [DW-1:0] orig31;
        w1     = 96'h1111_2222_3333_4444_5555_6666;
        w2     = 96'h7777_8888_9999_AAAA_BBBB_CCCC;
        orig31 = {64'h0, 24'hC0DE00, 8'h31};
        req = 5'b00001;
        wen = 5'b00001;
        set_wr(MST_CODER, 8'h30, w1);
        @(posedge clk);
        @(posedge clk); #1;
        set_wr(MST_CODER, 8'h31, w2);
        set_rd(MST_CODER, 8'h10);
        ren = 5'b00001;
        #2;
        rst = 1'b0;
        #1;
        n_vec++; if (gnt !== 5'b0 || ram_wen !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL ar_immediate got=%b/%b/%b want=%b/0/0", gnt, ram_wen, busy, 5'b0); end
        @(posedge clk);
        @(negedge clk);
        n_vec++; if (rvalid !== 5'b0) begin n_err++; $display("FAIL ar_rvalid got=%b want=%b", rvalid, 5'b0); end
        @(posedge clk); #1;
        n_vec++; if (mem[8'h31] !== orig31) begin n_err++; $display("FAIL ar_no_write got=%h want=%h", mem[8'h31], orig31); end
        n_vec++; if (mem[8'h30] !== w1) begin n_err++; $display("FAIL ar_pre_write got=%h want=%h", mem[8'h30], w1); end
        rst = 1'b1;
        req = '0;
        ren = '0;
        wen = '0;
        @(posedge clk);
        @(negedge clk);
        n_vec++; if (rvalid !== 5'b0 || gnt !== 5'b0) begin n_err++; $display("FAIL ar_after got=%b/%b want=0/0", rvalid, gnt); end
        @(posedge clk); #1;
    endtask

    initial begin
        req   = '0;
        ren   = '0;
        wen   = '0;
        raddr = '0;
        waddr = '0;
        wdata = '0;
        rst   = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] <= {64'h0, 24'hC0DE00, 8'(i)};
        mem[8'h10] <= 96'hA5;
        mem[8'h11] <= 96'h5A5A_0011;
        #2;
        rst = 1'b0;

        test_reset();
        test_round_robin();
        test_release_handover();
        test_read_routing();
        test_write_gating();
        test_async_reset();

        repeat (3) @(posedge clk);
        n_vec++;
        if (sb.size() !== 0) begin
            n_err++;
            $display("FAIL rd_outstanding got=%0d want=0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
